drive_arbiter: RTL and testbench
================================

DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 Parameter DEAD_CYCLES, default 2_500_000; STOP interval inserted between two different moving commands (50 ms at 50 MHz).
REQ-002 Parameter MIN_HOLD, default 5_000_000; minimum cycles a new moving command is held before a same-owner change to another moving command (100 ms).
REQ-003 Parameter BT_TIMEOUT, default 100_000_000; cycles without Bluetooth activity before the Bluetooth request is ignored (2 s).
REQ-004 clk  in  1  system clock, 50 MHz; the only clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 bl_ctr  in  3  Bluetooth drive request.
REQ-007 bl_en  in  1  Bluetooth control enable.
REQ-008 csb_ctr  in  3  ultrasonic avoidance request.
REQ-009 csb_en  in  1  ultrasonic avoidance active.
REQ-010 csb_en_negedge  in  1  ultrasonic avoidance tail (post-avoid) active.
REQ-011 hw_ctr  in  3  infrared line-follow request; always valid.
REQ-012 ctr  out  3  registered command to the PWM block.
REQ-013 owner  out  2  source of ctr: 0 none, 1 infrared, 2 ultrasonic, 3 Bluetooth.
REQ-014 dead  out  1  high while a dead-time STOP is being driven.
REQ-015 bt_stale  out  1  high while the Bluetooth watchdog is expired.

Function
REQ-016 Encoding: 0 STOP, 1 FORWARD, 2 BACKWARD, 3 LEFT, 4 RIGHT; codes 5-7 are treated as STOP on every input.
REQ-017 Request select each cycle: Bluetooth if bl_en=1 and bt_stale=0; else ultrasonic if csb_en|csb_en_negedge; else infrared; owner reflects the selected source.
REQ-018 Watchdog: counter reloads to 0 on any cycle where bl_ctr differs from its previous-cycle value or bl_en rises; increments otherwise, saturating; bt_stale=1 once count reaches BT_TIMEOUT-1, clears the cycle after a reload.
REQ-019 FSM states STOPPED, RUN, DEAD; all outputs registered, one-cycle latency from input to ctr.
REQ-020 STOPPED: ctr=0; a moving request loads ctr next cycle, enters RUN, clears the hold counter.
REQ-021 RUN: request equal to ctr -> no change; request STOP -> ctr=0 next cycle, enter STOPPED, regardless of hold.
REQ-022 RUN, request moving and different: taken only if hold counter >= MIN_HOLD-1 or owner changed to a higher-priority source; then ctr=0, dead=1, enter DEAD; otherwise request ignored and ctr kept.
REQ-023 DEAD: ctr=0, counter runs DEAD_CYCLES cycles; at the last cycle load the current request (not the one that started DEAD) and enter RUN, or enter STOPPED if it is STOP.
REQ-024 DEAD with request becoming STOP: exit immediately to STOPPED next cycle, dead=0.
REQ-025 Owner priority change to a lower source never bypasses MIN_HOLD.
REQ-026 Counters saturate; no wrap-around; widths sized from the parameters.

Reset
REQ-027 reset low asynchronously forces ctr=0, owner=0, dead=0, bt_stale=0, state STOPPED, all counters 0.
REQ-028 Deasserting reset mid-DEAD or mid-RUN resumes from STOPPED; no partial dead-time is carried over.
REQ-029 First owner update occurs on the first clk edge after reset deasserts.

Verification (DEAD_CYCLES=4, MIN_HOLD=8, BT_TIMEOUT=16)
REQ-030 Reset, hw_ctr=1, others idle -> ctr=1, owner=1 one cycle after release; dead=0.
REQ-031 Run ctr=1 for 10 cycles, hw_ctr->2 -> ctr=0, dead=1 for 4 cycles, then ctr=2.
REQ-032 ctr=1 for 3 cycles, hw_ctr->4 -> ignored until hold counter reaches 7, then dead-time, then ctr=4; hw_ctr->0 any time -> ctr=0 next cycle.
REQ-033 hw_ctr=1 running, csb_en=1 csb_ctr=3 at cycle 2 -> owner=2, immediate dead-time (hold bypass), then ctr=3; csb_en and csb_en_negedge low -> back to hw after MIN_HOLD.
REQ-034 bl_en=1 bl_ctr=1 constant 16 cycles -> bt_stale=1, owner falls to ultrasonic/infrared; bl_ctr->2 -> bt_stale=0, owner=3.
REQ-035 reset asserted during DEAD -> all outputs 0 that same cycle, no clock edge required.

Source files
------------

// File: rtl/drive_arbiter.sv
// Drive command arbiter: picks Bluetooth, ultrasonic or infrared drive requests,
// enforces a minimum hold time and a STOP dead-time between direction changes,
// and drops a silent Bluetooth link after a watchdog timeout.
module drive_arbiter #(
  parameter int unsigned DEAD_CYCLES = 2_500_000,
  parameter int unsigned MIN_HOLD    = 5_000_000,
  parameter int unsigned BT_TIMEOUT  = 100_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] bl_ctr_i,
  input  logic       bl_en_i,
  input  logic [2:0] csb_ctr_i,
  input  logic       csb_en_i,
  input  logic       csb_en_negedge_i,
  input  logic [2:0] hw_ctr_i,
  output logic [2:0] ctr_o,
  output logic [1:0] owner_o,
  output logic       dead_o,
  output logic       bt_stale_o
);

  localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned HoldW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam int unsigned WdW   = (BT_TIMEOUT > 1) ? $clog2(BT_TIMEOUT) : 1;

  localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MIN_HOLD - 1);
  localparam logic [WdW-1:0]   WdLast   = WdW'(BT_TIMEOUT - 1);

  localparam logic [1:0] StStopped = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StDead    = 2'd2;

  localparam logic [1:0] OwnIr = 2'd1;
  localparam logic [1:0] OwnUs = 2'd2;
  localparam logic [1:0] OwnBt = 2'd3;

  // Undefined codes 5-7 collapse to STOP.
  function automatic logic [2:0] legal_cmd(input logic [2:0] c);
    return (c > 3'd4) ? 3'd0 : c;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       ctr_q, ctr_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       cmd_owner_q, cmd_owner_d;
  logic             dead_q, dead_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [DeadW-1:0] dead_cnt_q, dead_cnt_d;
  logic [WdW-1:0]   wd_cnt_q, wd_cnt_d;
  logic             bt_stale_q, bt_stale_d;
  logic [2:0]       bl_ctr_prev_q;
  logic             bl_en_prev_q;
  logic             wd_reload;
  logic [2:0]       req;
  logic [1:0]       req_owner;

  // Source selection by fixed priority.
  always_comb begin
    req       = legal_cmd(hw_ctr_i);
    req_owner = OwnIr;
    if (bl_en_i && !bt_stale_q) begin
      req       = legal_cmd(bl_ctr_i);
      req_owner = OwnBt;
    end else if (csb_en_i || csb_en_negedge_i) begin
      req       = legal_cmd(csb_ctr_i);
      req_owner = OwnUs;
    end
  end

  // Bluetooth watchdog: any change on bl_ctr or a rising bl_en counts as activity.
  always_comb begin
    wd_reload = (bl_ctr_i != bl_ctr_prev_q) || (bl_en_i && !bl_en_prev_q);
    if (wd_reload) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q == WdLast) begin
      wd_cnt_d = wd_cnt_q;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    bt_stale_d = (wd_cnt_d == WdLast);
  end

  // Command FSM: STOPPED / RUN / DEAD with hold and dead-time counters.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    dead_d      = 1'b0;
    hold_d      = hold_q;
    dead_cnt_d  = dead_cnt_q;
    cmd_owner_d = cmd_owner_q;
    owner_d     = req_owner;
    case (state_q)
      StStopped: begin
        ctr_d = 3'd0;
        if (req != 3'd0) begin
          ctr_d       = req;
          state_d     = StRun;
          hold_d      = '0;
          cmd_owner_d = req_owner;
        end
      end
      StRun: begin
        if (hold_q != HoldLast) begin
          hold_d = hold_q + 1'b1;
        end
        if (req == 3'd0) begin
          ctr_d   = 3'd0;
          state_d = StStopped;
        end else if (req != ctr_q) begin
          // Only a strictly higher-priority source may skip the hold time.
          if (hold_q == HoldLast || req_owner > cmd_owner_q) begin
            ctr_d      = 3'd0;
            dead_d     = 1'b1;
            dead_cnt_d = '0;
            state_d    = StDead;
          end
        end
      end
      StDead: begin
        ctr_d = 3'd0;
        if (req == 3'd0) begin
          state_d = StStopped;
        end else if (dead_cnt_q == DeadLast) begin
          // Load whatever is requested now, not what started the dead-time.
          ctr_d       = req;
          state_d     = StRun;
          hold_d      = '0;
          cmd_owner_d = req_owner;
        end else begin
          dead_d     = 1'b1;
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StStopped;
        ctr_d   = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StStopped;
      ctr_q         <= 3'd0;
      owner_q       <= 2'd0;
      cmd_owner_q   <= 2'd0;
      dead_q        <= 1'b0;
      hold_q        <= '0;
      dead_cnt_q    <= '0;
      wd_cnt_q      <= '0;
      bt_stale_q    <= 1'b0;
      bl_ctr_prev_q <= 3'd0;
      bl_en_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      owner_q       <= owner_d;
      cmd_owner_q   <= cmd_owner_d;
      dead_q        <= dead_d;
      hold_q        <= hold_d;
      dead_cnt_q    <= dead_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      bt_stale_q    <= bt_stale_d;
      bl_ctr_prev_q <= bl_ctr_i;
      bl_en_prev_q  <= bl_en_i;
    end
  end

  assign ctr_o      = ctr_q;
  assign owner_o    = owner_q;
  assign dead_o     = dead_q;
  assign bt_stale_o = bt_stale_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter with short timing parameters: a per-cycle vector
// table for infrared/ultrasonic arbitration plus hand-written Bluetooth
// watchdog and asynchronous-reset sequences.
module tb_drive_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] bl_ctr, csb_ctr, hw_ctr;
  logic       bl_en, csb_en, csb_neg;
  logic [2:0] ctr;
  logic [1:0] owner;
  logic       dead, bt_stale;

  int n_checks = 0;
  int n_err    = 0;

  drive_arbiter #(
    .DEAD_CYCLES(4),
    .MIN_HOLD   (8),
    .BT_TIMEOUT (16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .bl_ctr_i        (bl_ctr),
    .bl_en_i         (bl_en),
    .csb_ctr_i       (csb_ctr),
    .csb_en_i        (csb_en),
    .csb_en_negedge_i(csb_neg),
    .hw_ctr_i        (hw_ctr),
    .ctr_o           (ctr),
    .owner_o         (owner),
    .dead_o          (dead),
    .bt_stale_o      (bt_stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] hw;
    logic       ce;
    logic       cn;
    logic [2:0] cc;
    logic [2:0] e_ctr;
    logic [1:0] e_own;
    logic       e_dead;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [2:0] hw, input logic ce, input logic cn,
                     input logic [2:0] cc, input logic [2:0] e_ctr, input logic [1:0] e_own,
                     input logic e_dead);
    vec_t v;
    v.hw = hw; v.ce = ce; v.cn = cn; v.cc = cc;
    v.e_ctr = e_ctr; v.e_own = e_own; v.e_dead = e_dead;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; bl_ctr = 3'd0; bl_en = 1'b0; csb_ctr = 3'd0; csb_en = 1'b0;
    csb_neg = 1'b0; hw_ctr = 3'd1;

    //  n  hw ce cn cc   ctr own dead
    add(10, 1, 0, 0, 0,  1, 1, 0);  // first load, then hold builds up
    add(4,  2, 0, 0, 0,  0, 1, 1);  // hold satisfied: dead-time
    add(3,  2, 0, 0, 0,  2, 1, 0);
    add(5,  4, 0, 0, 0,  2, 1, 0);  // ignored until hold reaches 7
    add(4,  4, 0, 0, 0,  0, 1, 1);
    add(1,  4, 0, 0, 0,  4, 1, 0);
    add(1,  0, 0, 0, 0,  0, 1, 0);  // STOP is immediate
    add(1,  3, 0, 0, 0,  3, 1, 0);
    add(1,  0, 0, 0, 0,  0, 1, 0);
    add(1,  1, 0, 0, 0,  1, 1, 0);
    add(1,  6, 0, 0, 0,  0, 1, 0);  // illegal code means STOP
    add(2,  1, 0, 0, 0,  1, 1, 0);
    add(4,  1, 1, 0, 3,  0, 2, 1);  // ultrasonic preempts without hold
    add(1,  1, 1, 0, 3,  3, 2, 0);
    add(7,  1, 0, 0, 0,  3, 1, 0);  // back to infrared needs full hold
    add(1,  1, 0, 0, 0,  0, 1, 1);
    add(1,  0, 0, 0, 0,  0, 1, 0);  // STOP during dead-time exits at once
    add(1,  1, 0, 0, 0,  1, 1, 0);
    add(1,  1, 0, 1, 4,  0, 2, 1);  // post-avoid tail preempts
    add(3,  1, 0, 1, 3,  0, 2, 1);
    add(1,  1, 0, 1, 3,  3, 2, 0);  // loads request current at dead-time end

    step();
    check("reset ctr", ctr, 0);
    check("reset owner", owner, 0);
    check("reset dead", dead, 0);
    check("reset bt_stale", bt_stale, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      hw_ctr = vecs[i].hw; csb_en = vecs[i].ce; csb_neg = vecs[i].cn; csb_ctr = vecs[i].cc;
      step();
      check($sformatf("v%0d ctr", i), ctr, vecs[i].e_ctr);
      check($sformatf("v%0d owner", i), owner, vecs[i].e_own);
      check($sformatf("v%0d dead", i), dead, vecs[i].e_dead);
    end

    // Bluetooth watchdog sequence from a clean reset.
    rst_n = 1'b0; hw_ctr = 3'd0; csb_en = 1'b0; csb_neg = 1'b0; csb_ctr = 3'd0;
    step();
    rst_n = 1'b1;
    bl_en = 1'b1; bl_ctr = 3'd1;
    step();
    check("bt load ctr", ctr, 1);
    check("bt load owner", owner, 3);
    for (int k = 1; k <= 14; k++) step();
    check("bt not yet stale", bt_stale, 0);
    step();
    check("bt stale after 16", bt_stale, 1);
    check("bt owner at expiry", owner, 3);
    step();
    check("stale owner falls back", owner, 1);
    check("stale ctr follows infrared", ctr, 0);
    bl_ctr = 3'd2;
    step();
    check("stale clears after activity", bt_stale, 0);
    check("owner one cycle after activity", owner, 1);
    step();
    check("bt owner restored", owner, 3);
    check("bt ctr restored", ctr, 2);

    // Same-owner change waits for hold, then async reset in the middle of dead-time.
    bl_ctr = 3'd4;
    for (int k = 0; k < 7; k++) step();
    check("bt change held off", ctr, 2);
    step();
    check("bt dead entered", dead, 1);
    check("bt dead ctr", ctr, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset ctr", ctr, 0);
    check("async reset owner", owner, 0);
    check("async reset dead", dead, 0);
    check("async reset bt_stale", bt_stale, 0);
    step();
    check("held reset dead", dead, 0);
    bl_en = 1'b0; bl_ctr = 3'd0; hw_ctr = 3'd1;
    rst_n = 1'b1;
    step();
    check("resume ctr", ctr, 1);
    check("resume owner", owner, 1);
    check("resume no dead", dead, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
